// File: rtl/wbu_br_commit_pkg.sv
// Shared flush encodings and exception-trace-word bit positions for the
// writeback branch-commit slice.
package wbu_br_commit_pkg;

    typedef enum logic [1:0] {
        FLUSH_NONE = 2'd0,
        FLUSH_BR   = 2'd1,
        FLUSH_EXC  = 2'd2
    } flush_kind_e;

    // ETW bit flagging a misaligned instruction-fetch target.
    localparam int ET_AdEL_IF = 4;

endpackage

// File: rtl/wbu_br_commit.sv
// Writeback branch commit: writes link values, holds a taken branch until its
// delay slot commits, then broadcasts the branch flush and the fetch redirect.
module wbu_br_commit
    import wbu_br_commit_pkg::*;
#(
    parameter int BID_W = 4,
    parameter int ETW_W = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             res_tvalid,
    output logic             res_tready,
    input  logic [31:0]      res_target,
    input  logic             res_is_taken,
    input  logic [31:0]      res_val,
    input  logic [4:0]       res_rd,
    input  logic             res_rd_wen,
    input  logic [31:0]      res_PC,
    input  logic             res_is_delayslot,
    input  logic [BID_W-1:0] res_branch_id,
    input  logic [ETW_W-1:0] res_ETW,

    input  logic             ds_commit,
    input  logic [BID_W-1:0] ds_branch_id,
    input  logic             ext_flush,

    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,

    output logic             flush_tvalid,
    output logic [1:0]       flush_kind,
    output logic [BID_W-1:0] flush_branch_id,

    output logic             redir_tvalid,
    input  logic             redir_tready,
    output logic [31:0]      redir_target,

    output logic             exc_tvalid,
    output logic [31:0]      exc_epc,
    output logic [31:0]      exc_badvaddr
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_DS, ST_REDIR} state_e;

    state_e             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [BID_W-1:0]   bid_q, bid_d;

    logic               rf_wen_q, rf_wen_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic               flush_tvalid_q, flush_tvalid_d;
    flush_kind_e        flush_kind_q, flush_kind_d;
    logic [BID_W-1:0]   flush_bid_q, flush_bid_d;
    logic               exc_tvalid_q, exc_tvalid_d;
    logic [31:0]        exc_epc_q, exc_epc_d;
    logic [31:0]        exc_badvaddr_q, exc_badvaddr_d;

    logic               adel;
    logic               accept;

    // The delay-slot flag and the other ETW bits are carried by the BRU but
    // play no part in commit decisions here.
    logic               unused_fields;
    assign unused_fields = ^{res_is_delayslot, res_ETW};

    assign adel = res_ETW[ET_AdEL_IF];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        target_d       = target_q;
        bid_d          = bid_q;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = '0;
        rf_wdata_d     = '0;
        flush_tvalid_d = 1'b0;
        flush_kind_d   = FLUSH_NONE;
        flush_bid_d    = '0;
        exc_tvalid_d   = 1'b0;
        exc_epc_d      = '0;
        exc_badvaddr_d = '0;
        res_tready     = 1'b0;

        // Accept a new result in the very cycle the redirect is taken.
        unique case (state_q)
            ST_IDLE:  res_tready = 1'b1;
            ST_REDIR: res_tready = redir_tready;
            default:  res_tready = 1'b0;
        endcase
        if (rst) begin
            res_tready = 1'b0;
        end
        accept = res_tvalid && res_tready;

        if (ext_flush) begin
            // A consumed result is simply dropped.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_WAIT_DS: begin
                    if (ds_commit && (ds_branch_id == bid_q)) begin
                        flush_tvalid_d = 1'b1;
                        flush_kind_d   = FLUSH_BR;
                        flush_bid_d    = bid_q;
                        state_d        = ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    if (redir_tready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                rf_wen_d   = res_rd_wen && !adel;
                rf_waddr_d = res_rd;
                rf_wdata_d = res_val;
                if (adel) begin
                    exc_tvalid_d   = 1'b1;
                    exc_epc_d      = res_PC;
                    exc_badvaddr_d = res_target;
                    flush_tvalid_d = 1'b1;
                    flush_kind_d   = FLUSH_EXC;
                    flush_bid_d    = res_branch_id;
                end else if (res_is_taken) begin
                    target_d = res_target;
                    bid_d    = res_branch_id;
                    state_d  = ST_WAIT_DS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            bid_q          <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            flush_tvalid_q <= 1'b0;
            flush_kind_q   <= FLUSH_NONE;
            flush_bid_q    <= '0;
            exc_tvalid_q   <= 1'b0;
            exc_epc_q      <= '0;
            exc_badvaddr_q <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            bid_q          <= bid_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            flush_tvalid_q <= flush_tvalid_d;
            flush_kind_q   <= flush_kind_d;
            flush_bid_q    <= flush_bid_d;
            exc_tvalid_q   <= exc_tvalid_d;
            exc_epc_q      <= exc_epc_d;
            exc_badvaddr_q <= exc_badvaddr_d;
        end
    end

    assign rf_wen          = rf_wen_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign flush_tvalid    = flush_tvalid_q;
    assign flush_kind      = flush_kind_q;
    assign flush_branch_id = flush_bid_q;
    assign redir_tvalid    = (state_q == ST_REDIR);
    assign redir_target    = target_q;
    assign exc_tvalid      = exc_tvalid_q;
    assign exc_epc         = exc_epc_q;
    assign exc_badvaddr    = exc_badvaddr_q;

endmodule

// File: tb/tb_wbu_br_commit.sv
// Scoreboard bench for wbu_br_commit: stimulus queues expected output events,
// a monitor pops and compares them whenever the DUT emits one.
module tb_wbu_br_commit;
    import wbu_br_commit_pkg::*;

    localparam int BID_W = 4;
    localparam int ETW_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             res_tvalid = 1'b0;
    logic             res_tready;
    logic [31:0]      res_target = '0;
    logic             res_is_taken = 1'b0;
    logic [31:0]      res_val = '0;
    logic [4:0]       res_rd = '0;
    logic             res_rd_wen = 1'b0;
    logic [31:0]      res_PC = '0;
    logic             res_is_delayslot = 1'b0;
    logic [BID_W-1:0] res_branch_id = '0;
    logic [ETW_W-1:0] res_ETW = '0;
    logic             ds_commit = 1'b0;
    logic [BID_W-1:0] ds_branch_id = '0;
    logic             ext_flush = 1'b0;
    logic             rf_wen;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             flush_tvalid;
    logic [1:0]       flush_kind;
    logic [BID_W-1:0] flush_branch_id;
    logic             redir_tvalid;
    logic             redir_tready = 1'b0;
    logic [31:0]      redir_target;
    logic             exc_tvalid;
    logic [31:0]      exc_epc;
    logic [31:0]      exc_badvaddr;

    wbu_br_commit #(.BID_W(BID_W), .ETW_W(ETW_W)) dut (
        .clk(clk), .rst(rst),
        .res_tvalid(res_tvalid), .res_tready(res_tready),
        .res_target(res_target), .res_is_taken(res_is_taken),
        .res_val(res_val), .res_rd(res_rd), .res_rd_wen(res_rd_wen),
        .res_PC(res_PC), .res_is_delayslot(res_is_delayslot),
        .res_branch_id(res_branch_id), .res_ETW(res_ETW),
        .ds_commit(ds_commit), .ds_branch_id(ds_branch_id),
        .ext_flush(ext_flush),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush_tvalid(flush_tvalid), .flush_kind(flush_kind),
        .flush_branch_id(flush_branch_id),
        .redir_tvalid(redir_tvalid), .redir_tready(redir_tready),
        .redir_target(redir_target),
        .exc_tvalid(exc_tvalid), .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_RF, EV_EXC, EV_FLUSH, EV_REDIR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push(input ev_kind_e kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic expect_event(input ev_kind_e kind, input logic [31:0] a,
                                input logic [31:0] b);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got %s a=0x%0h b=0x%0h, expected none at %0t",
                     kind.name(), a, b, $time);
        end else begin
            e = sb.pop_front();
            check({"event_kind_", e.kind.name()}, 32'(kind), 32'(e.kind));
            check({"event_a_", e.kind.name()}, a, e.a);
            check({"event_b_", e.kind.name()}, b, e.b);
        end
    endtask

    // Monitor: fixed per-cycle order rf, exc, flush, redir.
    initial begin
        forever begin
            @(negedge clk);
            if (rf_wen)       expect_event(EV_RF, 32'(rf_waddr), rf_wdata);
            if (exc_tvalid)   expect_event(EV_EXC, exc_epc, exc_badvaddr);
            if (flush_tvalid) expect_event(EV_FLUSH, 32'(flush_kind), 32'(flush_branch_id));
            if (redir_tvalid && redir_tready) expect_event(EV_REDIR, redir_target, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic send_result(input logic [31:0] pc, input logic [31:0] target,
                               input logic taken, input logic [31:0] val,
                               input logic [4:0] rd, input logic rd_wen,
                               input logic [BID_W-1:0] id, input logic adel_bit);
        int n;
        res_PC        = pc;
        res_target    = target;
        res_is_taken  = taken;
        res_val       = val;
        res_rd        = rd;
        res_rd_wen    = rd_wen;
        res_branch_id = id;
        res_ETW       = adel_bit ? (ETW_W'(1) << ET_AdEL_IF) : '0;
        res_tvalid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!res_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
        next();
        res_tvalid = 1'b0;
        res_ETW    = '0;
    endtask

    task automatic pulse_ds(input logic [BID_W-1:0] id);
        ds_commit    = 1'b1;
        ds_branch_id = id;
        next();
        ds_commit    = 1'b0;
    endtask

    task automatic do_redir(input int stall, input logic [31:0] tgt);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("redir_hold_valid", 32'(redir_tvalid), 32'd1);
            check("redir_hold_target", redir_target, tgt);
            next();
        end
        redir_tready = 1'b1;
        @(negedge clk);
        check("redir_valid_at_accept", 32'(redir_tvalid), 32'd1);
        next();
        redir_tready = 1'b0;
        @(negedge clk);
        check("tready_after_redir", 32'(res_tready), 32'd1);
        check("redir_dropped", 32'(redir_tvalid), 32'd0);
        next();
    endtask

    task automatic check_wait_ds(input string name);
        @(negedge clk);
        check({name, "_tready"}, 32'(res_tready), 32'd0);
        check({name, "_redir"}, 32'(redir_tvalid), 32'd0);
        next();
    endtask

    initial begin
        // Reset
        next();
        next();
        @(negedge clk);
        check("rst_tready", 32'(res_tready), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_flush", 32'(flush_tvalid), 32'd0);
        check("rst_redir", 32'(redir_tvalid), 32'd0);
        check("rst_exc", 32'(exc_tvalid), 32'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 32'(res_tready), 32'd1);
        next();

        // Not-taken BNE, no link write
        send_result(32'h100, 32'h180, 1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("bne_tready", 32'(res_tready), 32'd1);
        next();

        // Back-to-back not-taken results with link writes, one per cycle
        push(EV_RF, 32'd4, 32'h11);
        send_result(32'h110, 32'h0, 1'b0, 32'h11, 5'd4, 1'b1, 4'd0, 1'b0);
        push(EV_RF, 32'd5, 32'h22);
        send_result(32'h114, 32'h0, 1'b0, 32'h22, 5'd5, 1'b1, 4'd0, 1'b0);
        next();

        // Taken JAL: link r31, delay slot two cycles later, redirect stalled 2
        push(EV_RF, 32'd31, 32'h208);
        send_result(32'h200, 32'h400, 1'b1, 32'h208, 5'd31, 1'b1, 4'd3, 1'b0);
        check_wait_ds("jal_wait");
        push(EV_FLUSH, 32'(FLUSH_BR), 32'd3);
        push(EV_REDIR, 32'h400, 32'd0);
        pulse_ds(4'd3);
        do_redir(2, 32'h400);

        // JR to misaligned target: exception flush, no link write, no redirect
        push(EV_EXC, 32'h300, 32'h402);
        push(EV_FLUSH, 32'(FLUSH_EXC), 32'd5);
        send_result(32'h300, 32'h402, 1'b1, 32'h308, 5'd31, 1'b1, 4'd5, 1'b1);
        @(negedge clk);
        check("adel_tready", 32'(res_tready), 32'd1);
        check("adel_no_redir", 32'(redir_tvalid), 32'd0);
        next();

        // Non-matching delay-slot commit is ignored
        send_result(32'h500, 32'h600, 1'b1, 32'h0, 5'd0, 1'b0, 4'd1, 1'b0);
        pulse_ds(4'd2);
        check_wait_ds("ds_mismatch");
        check_wait_ds("ds_mismatch2");
        push(EV_FLUSH, 32'(FLUSH_BR), 32'd1);
        push(EV_REDIR, 32'h600, 32'd0);
        pulse_ds(4'd1);
        do_redir(0, 32'h600);

        // ext_flush in WAIT_DS together with a matching delay-slot commit
        send_result(32'h700, 32'h800, 1'b1, 32'h0, 5'd0, 1'b0, 4'd6, 1'b0);
        ext_flush    = 1'b1;
        ds_commit    = 1'b1;
        ds_branch_id = 4'd6;
        next();
        ext_flush    = 1'b0;
        ds_commit    = 1'b0;
        @(negedge clk);
        check("xflush_ds_tready", 32'(res_tready), 32'd1);
        check("xflush_ds_redir", 32'(redir_tvalid), 32'd0);
        next();
        push(EV_RF, 32'd7, 32'h77);
        send_result(32'h710, 32'h0, 1'b0, 32'h77, 5'd7, 1'b1, 4'd0, 1'b0);

        // ext_flush in REDIR
        send_result(32'h880, 32'h900, 1'b1, 32'h0, 5'd0, 1'b0, 4'd7, 1'b0);
        push(EV_FLUSH, 32'(FLUSH_BR), 32'd7);
        pulse_ds(4'd7);
        @(negedge clk);
        check("xflush_redir_before", 32'(redir_tvalid), 32'd1);
        next();
        ext_flush = 1'b1;
        next();
        ext_flush = 1'b0;
        @(negedge clk);
        check("xflush_redir_drop", 32'(redir_tvalid), 32'd0);
        check("xflush_redir_tready", 32'(res_tready), 32'd1);
        next();

        // ext_flush in IDLE discards the result in that cycle
        ext_flush = 1'b1;
        send_result(32'h990, 32'h0, 1'b0, 32'h99, 5'd9, 1'b1, 4'd0, 1'b0);
        ext_flush = 1'b0;
        next();

        // Reset asserted while in REDIR
        push(EV_RF, 32'd9, 32'hA08);
        send_result(32'hA00, 32'hC00, 1'b1, 32'hA08, 5'd9, 1'b1, 4'd8, 1'b0);
        push(EV_FLUSH, 32'(FLUSH_BR), 32'd8);
        pulse_ds(4'd8);
        rst = 1'b1;
        @(negedge clk);
        check("redir_before_rst", 32'(redir_tvalid), 32'd1);
        check("tready_in_rst", 32'(res_tready), 32'd0);
        next();
        @(negedge clk);
        check("rst_redir_valid", 32'(redir_tvalid), 32'd0);
        check("rst_redir_target", redir_target, 32'd0);
        check("rst_flush_kind", 32'(flush_kind), 32'd0);
        check("rst_exc_epc", exc_epc, 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_tready_held", 32'(res_tready), 32'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_tready", 32'(res_tready), 32'd1);
        next();
        next();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wbu_br_commit.md
# wbu_br_commit

Branch-commit slice of the writeback stage. It consumes resolved branch results from the BRU, writes link values, and holds each taken branch until its delay slot commits. It then broadcasts the branch flush to the execution units and the redirect to fetch. Branch-target address errors (AdEL_IF in the ETW) are raised as exception flushes without waiting for the delay slot.

## Interface
- `BID_W`, 4: width of branch_id.
- `ETW_W`, 32: width of exception trace word; bit `ET_AdEL_IF` marks a misaligned fetch target.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `res_tvalid` in 1 / `res_tready` out 1: BRU result handshake.
- `res_target` in 32, `res_is_taken` in 1, `res_val` in 32, `res_rd` in 5, `res_rd_wen` in 1, `res_PC` in 32, `res_is_delayslot` in 1, `res_branch_id` in BID_W, `res_ETW` in ETW_W: BRU result fields.
- `ds_commit` in 1, `ds_branch_id` in BID_W: another WBU port committed a delay-slot instruction tagged with this id, pulse.
- `ext_flush` in 1: exception flush from another unit, pulse; kills any pending branch.
- `rf_wen` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port.
- `flush_tvalid` out 1, `flush_kind` out 2, `flush_branch_id` out BID_W: flush broadcast (WBU→units); no ready, one-cycle pulse.
- `redir_tvalid` out 1 / `redir_tready` in 1, `redir_target` out 32: fetch redirect.
- `exc_tvalid` out 1, `exc_epc` out 32, `exc_badvaddr` out 32: exception request to CP0, one-cycle pulse.

## Operation
- FSM states: IDLE, WAIT_DS, REDIR.
- **IDLE:** `res_tready`=1. On an accepted result (`res_tvalid & res_tready`):
  - **Link write:** rf_wen=res_rd_wen & no AdEL, waddr=res_rd, wdata=res_val. Registered, so the write appears the next cycle. rd=0 still writes; the RF ignores it.
  - **AdEL_IF set:** pulse exc_tvalid with epc=res_PC and badvaddr=res_target. Pulse flush_tvalid with kind=FLUSH_EXC and branch_id=res_branch_id. Stay in IDLE.
  - **Taken, no AdEL:** latch target and branch_id, go to WAIT_DS.
  - **Not taken:** stay in IDLE, no flush.
- **WAIT_DS:** `res_tready`=0.
  - On `ds_commit && ds_branch_id==latched id`: pulse flush_tvalid with kind=FLUSH_BR and the latched id, assert redir_tvalid, go to REDIR.
  - A non-matching ds_commit is ignored.
- **REDIR:** redir_tvalid=1 with target held stable until redir_tready. On the handshake go to IDLE, and `res_tready` is 1 in that same cycle.
- **ext_flush:** has priority over everything. In WAIT_DS or REDIR it drops redir_tvalid and returns to IDLE with no flush emitted. In IDLE it discards that cycle's result: tready=1, consumed, no effects.
- **Simultaneous events:**
  - ds_commit together with ext_flush in WAIT_DS → ext_flush wins.
  - redir_tready arriving in the same cycle as the entry into REDIR cannot occur, because redir_tvalid is registered.
- **Reset values:** state=IDLE, res_tready=0 during reset, and all other outputs 0.

## Timing
- Result to RF write: 1 cycle.
- Result to exception/flush pulse: 1 cycle (registered outputs).
- Delay-slot commit to flush_tvalid and redir_tvalid: 1 cycle. Minimum taken-branch occupancy is 3 cycles.
- Back-to-back not-taken results: 1 per cycle.
- flush_tvalid and exc_tvalid are single-cycle pulses. redir_tvalid is level, held until accepted.
- Target arithmetic is done upstream; this block performs no address arithmetic.

## Structure
- Shared package/header (`flush.vh`): FLUSH_BR=2'd1, FLUSH_EXC=2'd2, FLUSH_NONE=2'd0, and the `ET_AdEL_IF` bit index (in `exception.vh`).
- FSM state encoding stays local.
- No sub-module. A single always block for the FSM plus registered output logic.

## Test plan
- **Not-taken BNE:** PC=0x100, A==B, rd_wen=0 → no rf_wen, no flush, tready stays 1.
- **Taken JAL:** PC=0x200, target=0x400, rd=31, id=3, then ds_commit id=3 two cycles later.
  - rf write r31=0x208 at cycle +1.
  - flush kind=BR id=3 one cycle after ds_commit.
  - redir 0x400 held until redir_tready, which is stalled 2 cycles.
- **JR with target=0x402, id=5** → exc_tvalid with epc=PC and badvaddr=0x402; flush kind=EXC id=5; no rf write; no redir.
- **Taken branch id=1, then ds_commit id=2** → ignored, still WAIT_DS. A later ds_commit id=1 → flush.
- **ext_flush during WAIT_DS and again during REDIR** → state returns to IDLE, redir_tvalid drops, no BR flush, next result accepted.
- **rst asserted in REDIR** → next cycle all outputs 0 and state IDLE. After rst drops, tready=1.
